// File: rtl/generador_frec_sel_if.sv
// Control/status bundle for generador_frec_sel.
// GEN_PULSO_EN adds the pulso strobe to the bundle.
interface generador_frec_sel_if;
  logic       enable;
  logic [2:0] frec_num;
  logic       frec_out;
  logic [2:0] sel_activa;
`ifdef GEN_PULSO_EN
  logic       pulso;

  modport master (output enable, frec_num, input frec_out, sel_activa, pulso);
  modport slave  (input enable, frec_num, output frec_out, sel_activa, pulso);
`else
  modport master (output enable, frec_num, input frec_out, sel_activa);
  modport slave  (input enable, frec_num, output frec_out, sel_activa);
`endif
endinterface

// File: rtl/generador_frec_sel.sv
// Square-wave divider with eight binary-spaced frequencies; selection reloads only at period end.
// Optional GEN_PULSO_EN: one-cycle pulso strobe after each rising edge of frec_out.
module generador_frec_sel #(
  parameter int BASE_HALF = 16,
  parameter int CNT_W     = 12
) (
  input  logic                 clk_nx,
  input  logic                 rst,
  generador_frec_sel_if.slave  bus
);

  if (BASE_HALF == 0 || (longint'(BASE_HALF) * 128) > (longint'(1) << CNT_W)) begin : g_cfg_err
    $error("generador_frec_sel: BASE_HALF must be nonzero and BASE_HALF<<7 must fit 2**CNT_W");
  end

  typedef enum logic {BAJO = 1'b0, ALTO = 1'b1} fase_t;

  fase_t            fase, fase_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       sel, sel_nx;
  logic [CNT_W-1:0] half, fin;

  // When half(0) equals 2**CNT_W it wraps to 0, and fin becomes all-ones: still correct.
  assign half = CNT_W'(BASE_HALF) << (3'd7 - sel);
  assign fin  = half - 1'b1;

`ifdef GEN_PULSO_EN
  logic pulso, pulso_nx;
`endif

  always_ff @(posedge clk_nx or posedge rst) begin
    if (rst) begin
      fase <= BAJO;
      cnt  <= '0;
      sel  <= '0;
`ifdef GEN_PULSO_EN
      pulso <= 1'b0;
`endif
    end else begin
      fase <= fase_nx;
      cnt  <= cnt_nx;
      sel  <= sel_nx;
`ifdef GEN_PULSO_EN
      pulso <= pulso_nx;
`endif
    end
  end

  always_comb begin
    fase_nx = fase;
    cnt_nx  = cnt;
    sel_nx  = sel;
`ifdef GEN_PULSO_EN
    pulso_nx = 1'b0;
`endif
    if (bus.enable) begin
      if (cnt == fin) begin
        cnt_nx = '0;
        case (fase)
          ALTO: begin
            fase_nx = BAJO;
            sel_nx  = bus.frec_num;  // full period done: take whatever is requested now
          end
          default: begin
            fase_nx = ALTO;
`ifdef GEN_PULSO_EN
            pulso_nx = 1'b1;
`endif
          end
        endcase
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  assign bus.frec_out   = fase;
  assign bus.sel_activa = sel;
`ifdef GEN_PULSO_EN
  assign bus.pulso      = pulso;
`endif

endmodule
